// File: rtl/ram256x8_loader.sv
// Byte-stream loader for a 256x8 RAM: writes a handshaked stream to addresses 0..LEN-1,
// keeps an additive checksum, and optionally reads the region back to verify it.
module ram256x8_loader #(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic       RWCLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [8:0] LEN,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       WEN,
  output logic [7:0] WADDR,
  output logic [7:0] WD,
  output logic       REN,
  output logic [7:0] RADDR,
  input  logic [7:0] RD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] CSUM
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StWflush, StVerify, StCheck, StFin
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] len_q, len_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] vsum_q, vsum_d;
  logic       rvld_q, rvld_d;
  logic       din_ready_q, din_ready_d;
  logic       wen_q, wen_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wd_q, wd_d;
  logic       ren_q, ren_d;
  logic [7:0] raddr_q, raddr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] vsum_final;

  // The last read's data is folded in while comparing, so CHECK needs no extra capture cycle.
  assign vsum_final = vsum_q + RD;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    vsum_d      = vsum_q;
    rvld_d      = ren_q;
    din_ready_d = din_ready_q;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wd_d        = wd_q;
    ren_d       = 1'b0;
    raddr_d     = raddr_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        if (START) begin
          if (LEN != 9'd0 && LEN <= 9'd256) begin
            len_d       = LEN;
            csum_d      = 8'd0;
            vsum_d      = 8'd0;
            err_d       = 1'b0;
            cnt_d       = 9'd0;
            din_ready_d = 1'b1;
            state_d     = StLoad;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (DIN_VALID && din_ready_q) begin
          wen_d   = 1'b1;
          waddr_d = cnt_q[7:0];
          wd_d    = DIN;
          csum_d  = csum_q + DIN;
          cnt_d   = cnt_q + 9'd1;
          // 9-bit compare so LEN=256 ends on count, not on the 8-bit address wrapping.
          if (cnt_q + 9'd1 == len_q) begin
            din_ready_d = 1'b0;
            state_d     = StWflush;
          end
        end
      end
      StWflush: begin
        if (VERIFY_EN) begin
          ren_d   = 1'b1;
          raddr_d = 8'd0;
          cnt_d   = 9'd1;
          state_d = StVerify;
        end else begin
          state_d = StFin;
        end
      end
      StVerify: begin
        if (rvld_q) begin
          vsum_d = vsum_q + RD;
        end
        if (cnt_q == len_q) begin
          state_d = StCheck;
        end else begin
          ren_d   = 1'b1;
          raddr_d = cnt_q[7:0];
          cnt_d   = cnt_q + 9'd1;
        end
      end
      StCheck: begin
        vsum_d  = vsum_final;
        err_d   = (vsum_final != csum_q);
        state_d = StFin;
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge RWCLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      len_q       <= 9'd0;
      cnt_q       <= 9'd0;
      csum_q      <= 8'd0;
      vsum_q      <= 8'd0;
      rvld_q      <= 1'b0;
      din_ready_q <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= 8'd0;
      wd_q        <= 8'd0;
      ren_q       <= 1'b0;
      raddr_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      vsum_q      <= vsum_d;
      rvld_q      <= rvld_d;
      din_ready_q <= din_ready_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wd_q        <= wd_d;
      ren_q       <= ren_d;
      raddr_q     <= raddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign DIN_READY = din_ready_q;
  assign WEN       = wen_q;
  assign WADDR     = waddr_q;
  assign WD        = wd_q;
  assign REN       = ren_q;
  assign RADDR     = raddr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign CSUM      = csum_q;

endmodule

// File: tb/tb_ram256x8_loader.sv
// Bench for ram256x8_loader: a RAM model, a verifying instance and a no-verify instance
// sharing the same stream; expectations come from a sum/sequence model of the load.
module tb_ram256x8_loader;

  logic       RWCLK, RESET, START, DIN_VALID;
  logic [8:0] LEN;
  logic [7:0] DIN, RD;
  logic       DIN_READY, WEN, REN, BUSY, DONE, ERR;
  logic [7:0] WADDR, WD, RADDR, CSUM;
  logic       nv_din_ready, nv_wen, nv_ren, nv_busy, nv_done, nv_err;
  logic [7:0] nv_waddr, nv_wd, nv_raddr, nv_csum;

  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  int         overlap = 0;
  int         corrupt_addr = -1;
  logic [7:0] mem [256];
  logic [7:0] stim [256];
  logic [7:0] base [4];
  logic [15:0] wq [$];
  logic [7:0]  rq [$];

  typedef struct {
    int len; int gap_at; int gap_len; int pat; int corrupt; int poke;
    int exp_done; int exp_err; int exp_csum;
  } vec_t;
  vec_t tbl [7];

  ram256x8_loader #(.VERIFY_EN(1'b1)) u_dut (
    .RWCLK(RWCLK), .RESET(RESET), .START(START), .LEN(LEN), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .WEN(WEN), .WADDR(WADDR), .WD(WD),
    .REN(REN), .RADDR(RADDR), .RD(RD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CSUM(CSUM)
  );

  ram256x8_loader #(.VERIFY_EN(1'b0)) u_dut_nv (
    .RWCLK(RWCLK), .RESET(RESET), .START(START), .LEN(LEN), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(nv_din_ready), .WEN(nv_wen), .WADDR(nv_waddr),
    .WD(nv_wd), .REN(nv_ren), .RADDR(nv_raddr), .RD(8'h00), .BUSY(nv_busy),
    .DONE(nv_done), .ERR(nv_err), .CSUM(nv_csum)
  );

  initial RWCLK = 1'b0;
  always #5 RWCLK = ~RWCLK;

  // RAM model with registered read; corrupt_addr perturbs one location on read.
  always @(posedge RWCLK) begin
    cyc <= cyc + 1;
    if (WEN) begin
      mem[WADDR] <= WD;
      wq.push_back({WADDR, WD});
    end
    if (REN) begin
      rq.push_back(RADDR);
      RD <= (corrupt_addr == int'(RADDR)) ? mem[RADDR] + 8'd1 : mem[RADDR];
    end
    if (WEN && REN) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge RWCLK);
    #1;
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 256; i++) begin
      if (pat == 0)      stim[i] = base[i % 4];
      else if (pat == 1) stim[i] = 8'(i);
      else               stim[i] = 8'($urandom);
    end
  endtask

  function automatic int model_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(stim[i]);
    return s % 256;
  endfunction

  task automatic run_load(input int n, input int gap_at, input int gap_len, input int poke,
                          input int exp_done, input int exp_err, input int exp_csum);
    int  e0, idx, gcnt, guard, done_at, nv_at, bad;
    bit  hs;
    wq.delete();
    rq.delete();
    START = 1'b1; LEN = 9'(n); DIN_VALID = 1'b0;
    tick();
    e0 = cyc;
    START = 1'b0;
    chk("start_busy", BUSY, 1);
    chk("start_err_clear", ERR, 0);
    chk("start_ready", DIN_READY, 1);
    idx = 0; gcnt = 0; guard = 0;
    while (idx < n && guard < 2000) begin
      if (idx == gap_at && gcnt < gap_len) begin
        DIN_VALID = 1'b0; DIN = 8'($urandom); gcnt++;
      end else begin
        DIN_VALID = 1'b1; DIN = stim[idx];
      end
      hs = DIN_VALID && DIN_READY;
      tick();
      if (hs) idx++;
      guard++;
    end
    DIN_VALID = 1'b0; DIN = 8'($urandom);
    chk("bytes_accepted", idx, n);
    done_at = -1; nv_at = -1; guard = 0;
    while (done_at < 0 && guard < 2000) begin
      if (poke > 0 && cyc - e0 == poke) begin
        START = 1'b1; LEN = 9'd7;
      end else begin
        START = 1'b0;
      end
      tick();
      guard++;
      if (nv_done && nv_at < 0) nv_at = cyc - e0;
      if (DONE) done_at = cyc - e0;
    end
    START = 1'b0;
    chk("done_edge", done_at, exp_done);
    chk("done_err", ERR, exp_err);
    chk("csum", CSUM, exp_csum);
    chk("nv_done_edge", nv_at, exp_done - n - 1);
    chk("nv_err", nv_err, 0);
    chk("nv_csum", nv_csum, exp_csum);
    tick();
    chk("done_width", DONE, 0);
    chk("idle_after_done", BUSY, 0);
    chk("err_held", ERR, exp_err);
    bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (i >= n || wq[i] != {8'(i), stim[i]}) bad++;
    chk("write_count", wq.size(), n);
    chk("write_seq_bad", bad, 0);
    bad = 0;
    for (int i = 0; i < rq.size(); i++)
      if (i >= n || int'(rq[i]) != i) bad++;
    chk("read_count", rq.size(), n);
    chk("read_seq_bad", bad, 0);
  endtask

  initial begin
    base[0] = 8'h10; base[1] = 8'h20; base[2] = 8'h30; base[3] = 8'hF0;
    //         len gap_at gap_len pat corrupt poke done err csum
    tbl[0] = '{4,   -1,   0,      0,  -1,     0,   11,  0,  'h50};
    tbl[1] = '{3,    2,   5,      0,  -1,     0,   14,  0,  'h60};
    tbl[2] = '{256, -1,   0,      1,  -1,     0,   515, 0,  'h80};
    tbl[3] = '{1,   -1,   0,      0,  -1,     0,   5,   0,  'h10};
    tbl[4] = '{4,   -1,   0,      0,   2,     4,   11,  1,  'h50};
    tbl[5] = '{4,   -1,   0,      0,  -1,     0,   11,  0,  'h50};
    tbl[6] = '{2,   -1,   0,      1,  -1,     0,   7,   0,  'h01};

    RESET = 1'b1; START = 1'b0; LEN = 9'd0; DIN = 8'd0; DIN_VALID = 1'b0;
    #2 RESET = 1'b0;
    tick(); tick();
    chk("reset_outputs", {DIN_READY, WEN, WADDR, WD, REN, RADDR, BUSY, DONE, ERR, CSUM}, 0);
    chk("reset_outputs_nv", {nv_din_ready, nv_wen, nv_busy, nv_done, nv_err, nv_csum}, 0);
    RESET = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      fill(tbl[v].pat);
      corrupt_addr = tbl[v].corrupt;
      run_load(tbl[v].len, tbl[v].gap_at, tbl[v].gap_len, tbl[v].poke,
               tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_csum);
    end
    corrupt_addr = -1;

    // Out-of-range lengths: immediate DONE with ERR, no RAM traffic.
    wq.delete(); rq.delete();
    START = 1'b1; LEN = 9'd0;
    tick();
    START = 1'b0;
    chk("len0_done", DONE, 1);
    chk("len0_err", ERR, 1);
    chk("len0_busy", BUSY, 0);
    tick();
    chk("len0_done_width", DONE, 0);
    START = 1'b1; LEN = 9'd300;
    tick();
    START = 1'b0;
    chk("len300_done", DONE, 1);
    chk("len300_err", ERR, 1);
    tick(); tick();
    chk("badlen_err_held", ERR, 1);
    chk("badlen_no_ram", wq.size() + rq.size(), 0);
    fill(2);
    run_load(3, -1, 0, 0, 9, 0, model_sum(3));

    // Asynchronous reset in the middle of a load.
    fill(2);
    START = 1'b1; LEN = 9'd8;
    tick();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      DIN_VALID = 1'b1; DIN = stim[i];
      tick();
    end
    #2 RESET = 1'b0;
    #1;
    chk("midload_reset", {DIN_READY, WEN, WADDR, WD, REN, RADDR, BUSY, DONE, ERR, CSUM}, 0);
    chk("midload_reset_nv", {nv_din_ready, nv_wen, nv_busy, nv_done, nv_csum}, 0);
    DIN_VALID = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    fill(2);
    run_load(2, -1, 0, 0, 7, 0, model_sum(2));

    // Randomised loads against the sum/sequence model.
    for (int r = 0; r < 10; r++) begin
      int n, ga, gl, cor;
      n  = int'($urandom_range(1, 40));
      ga = int'($urandom_range(0, n - 1));
      gl = int'($urandom_range(0, 4));
      cor = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : -1;
      fill(2);
      corrupt_addr = cor;
      run_load(n, ga, gl, 0, 2 * n + 3 + gl, (cor >= 0 && cor < n) ? 1 : 0, model_sum(n));
    end
    corrupt_addr = -1;

    chk("wen_ren_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
